// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter in front of sram_ctrl
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins every tie).
module sram_arbiter #(
    parameter int AW = 19,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_f2s,
    input  logic          ready,
    input  logic [DW-1:0] data_s2f
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   grant_any;
    logic   grant1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign grant1 = req1 & ~req0;
`else
    logic last;

    // On a tie, port 1 wins only when port 0 was granted last
    assign grant1 = req1 & (~req0 | ~last);

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (grant_any) begin
            last <= grant1;
        end
    end
`endif

    assign grant_any = (state == S_IDLE) & ready & (req0 | req1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            rw       <= 1'b1;
            addr     <= '0;
            data_f2s <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                owner    <= grant1;
                rw       <= grant1 ? ~we1 : ~we0;
                addr     <= grant1 ? addr1 : addr0;
                data_f2s <= grant1 ? wdata1 : wdata0;
            end
            // Capture on the WAIT->DONE edge so rdata is valid alongside ack
            if (state == S_WAIT && ready && rw) begin
                if (owner) rdata1 <= data_s2f;
                else       rdata0 <= data_s2f;
            end
        end
    end

    assign mem  = (state == S_ISSUE);
    assign busy = (state != S_IDLE);
    assign ack0 = (state == S_DONE) & ~owner;
    assign ack1 = (state == S_DONE) & owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, mem, rw;
    logic [DW-1:0] rdata0, rdata1, data_f2s;
    logic [AW-1:0] addr;
    logic          ready;
    logic [DW-1:0] data_s2f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
        .ready(ready), .data_s2f(data_s2f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // sram_ctrl model: ready drops the cycle after mem, returns two cycles later
    logic          ready_r;
    logic          force_low;
    logic [1:0]    cnt;
    logic          op_rd;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_data;
    logic [DW-1:0] mem_arr [32];

    initial for (int i = 0; i < 32; i++) mem_arr[i] = '0;

    assign ready = ready_r & ~force_low;

    always @(posedge clk) begin
        if (reset) begin
            ready_r  <= 1'b1;
            cnt      <= 2'd0;
            data_s2f <= '0;
        end else if (ready_r) begin
            if (mem) begin
                ready_r <= 1'b0;
                cnt     <= 2'd2;
                op_rd   <= rw;
                op_addr <= addr;
                op_data <= data_f2s;
            end
        end else begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
                ready_r <= 1'b1;
                if (op_rd) data_s2f <= mem_arr[op_addr[4:0]];
                else       mem_arr[op_addr[4:0]] <= op_data;
            end
        end
    end

    // Protocol monitor
    int            mem_count = 0;
    int            ack_count = 0;
    int            grants[$];
    logic          mem_prev = 1'b0;
    logic          in_txn = 1'b0;
    logic          cap_rw;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;

    always @(negedge clk) begin
        if (reset) begin
            in_txn   = 1'b0;
            mem_prev = 1'b0;
        end else begin
            if (ack0 & ack1) check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            if (mem & mem_prev) check("mem_consecutive", 32'(mem & mem_prev), 32'd0);
            if (mem) begin
                mem_count++;
                in_txn   = 1'b1;
                cap_rw   = rw;
                cap_addr = addr;
                cap_data = data_f2s;
            end else if (in_txn) begin
                check("stable_rw", 32'(rw), 32'(cap_rw));
                check("stable_addr", 32'(addr), 32'(cap_addr));
                check("stable_data", 32'(data_f2s), 32'(cap_data));
                if (ack0 | ack1) in_txn = 1'b0;
            end
            if (ack0) begin grants.push_back(0); ack_count++; end
            if (ack1) begin grants.push_back(1); ack_count++; end
            mem_prev = mem;
        end
    end

    // port 2 means either port; returns at the negedge of the ack cycle
    task automatic wait_ack(input int port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((port == 0 && ack0) || (port == 1 && ack1) || (port == 2 && (ack0 | ack1)))
                got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem"}, 32'(mem), 32'd0);
        check({tag, "_rw"}, 32'(rw), 32'd1);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_data_f2s"}, 32'(data_f2s), 32'd0);
        check({tag, "_ack"}, 32'({ack1, ack0}), 32'd0);
        check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int m0, a0;
    int exp_grant[4];
    logic seen;

    initial begin
        reset = 1'b1; force_low = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Single write from port 0
        @(posedge clk); #1;
        m0 = mem_count;
        req0 = 1; we0 = 1; addr0 = 19'h00005; wdata0 = 8'hA5;
        @(negedge clk);
        check("wr_idle_mem", 32'(mem), 32'd0);
        @(negedge clk);
        check("wr_mem", 32'(mem), 32'd1);
        check("wr_rw", 32'(rw), 32'd0);
        check("wr_addr", 32'(addr), 32'h5);
        check("wr_data", 32'(data_f2s), 32'hA5);
        check("wr_busy", 32'(busy), 32'd1);
        wait_ack(0);
        check("wr_rdata0", 32'(rdata0), 32'd0);
        @(posedge clk); #1 req0 = 0;
        check("wr_mem_pulses", 32'(mem_count - m0), 32'd1);
        @(negedge clk);
        check("wr_idle_busy", 32'(busy), 32'd0);

        // Read back through port 1
        @(posedge clk); #1 req1 = 1; we1 = 0; addr1 = 19'h00005;
        wait_ack(1);
        check("rd_rdata1", 32'(rdata1), 32'hA5);
        check("rd_rdata0", 32'(rdata0), 32'd0);
        @(posedge clk); #1 req1 = 0;

        // Tie: both hold requests across four transactions
        @(posedge clk); #1;
        grants.delete();
        req0 = 1; we0 = 0; addr0 = 19'h00005;
        req1 = 1; we1 = 0; addr1 = 19'h00007;
        for (int i = 0; i < 4; i++) wait_ack(2);
        @(posedge clk); #1 req0 = 0; req1 = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_grant = '{0, 0, 0, 0};
`else
        exp_grant = '{0, 1, 0, 1};
`endif
        check("tie_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("tie_grant%0d", i), 32'(grants[i]), 32'(exp_grant[i]));

        // Ready held low in IDLE blocks the grant
        @(posedge clk); #1 force_low = 1; req0 = 1; we0 = 1; addr0 = 19'h00007; wdata0 = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rdylow_mem", 32'(mem), 32'd0);
        end
        @(posedge clk); #1 force_low = 0;
        @(negedge clk);
        check("rdyrise_mem0", 32'(mem), 32'd0);
        @(negedge clk);
        check("rdyrise_mem1", 32'(mem), 32'd1);
        check("rdyrise_addr", 32'(addr), 32'h7);
        wait_ack(0);
        @(posedge clk); #1 req0 = 0;
        @(posedge clk); #1 req0 = 1; we0 = 0; addr0 = 19'h00007;
        wait_ack(0);
        check("rdylow_readback", 32'(rdata0), 32'h3C);
        @(posedge clk); #1 req0 = 0;

        // Reset during WAIT abandons the transaction
        @(posedge clk); #1 req1 = 1; we1 = 1; addr1 = 19'h00009; wdata1 = 8'h5A;
        a0 = ack_count;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem;
        end
        check("rstmid_issue_seen", 32'(seen), 32'd1);
        @(posedge clk); #1 reset = 1; req1 = 0;
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check_reset_vals("rstmid");
        @(posedge clk); #1 reset = 0;
        repeat (4) @(posedge clk);
        #1 check("rstmid_no_ack", 32'(ack_count - a0), 32'd0);
        req0 = 1; we0 = 0; addr0 = 19'h00005;
        wait_ack(0);
        check("rstmid_next_read", 32'(rdata0), 32'hA5);
        @(posedge clk); #1 req0 = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
